// File: rtl/vec_cache_writer.sv
// vec_cache_writer: packs a valid/ready stream of DATA_W-bit float words into
// WIDTH-lane vectors and drives the VecCache write port.
// Ports:
//   clock, reset                  rising-edge clock, async active-high reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_addr, cmd_count           first cache row, number of rows (0..DEPTH)
//   cmd_scalar                    1 = per-lane writes, 0 = whole-vector writes
//   elem_valid/elem_ready         element stream handshake, elem_data payload
//   write_op/write_addr/
//   write_param/vec_data          registered cache write port
//   done                          one-cycle pulse when a command completes

package vec_cache_writer_pkg;
  typedef enum logic [1:0] {
    VEC_DATA_WRITE_DISABLE = 2'd0,
    VEC_DATA_WRITE_VEC     = 2'd1,
    VEC_DATA_WRITE_SCALAR  = 2'd2
  } VecDataWriteOp_t;
endpackage

module vec_cache_writer
  import vec_cache_writer_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [$clog2(DEPTH)-1:0]     cmd_addr,
  input  logic [$clog2(DEPTH):0]       cmd_count,
  input  logic                         cmd_scalar,
  input  logic                         elem_valid,
  output logic                         elem_ready,
  input  logic [DATA_W-1:0]            elem_data,
  output VecDataWriteOp_t              write_op,
  output logic [$clog2(DEPTH)-1:0]     write_addr,
  output logic [$clog2(WIDTH)-1:0]     write_param,
  output logic [WIDTH-1:0][DATA_W-1:0] vec_data,
  output logic                         done
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILL   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t                       r_state;
  logic [LW-1:0]                r_lane;
  logic [AW-1:0]                r_row;
  logic [AW:0]                  r_remaining;
  logic                         r_scalar;
  logic [WIDTH-1:0][DATA_W-1:0] r_buf;

  VecDataWriteOp_t              r_write_op;
  logic [AW-1:0]                r_write_addr;
  logic [LW-1:0]                r_write_param;
  logic [WIDTH-1:0][DATA_W-1:0] r_vec_data;
  logic                         r_done;

  logic                         w_cmd_fire;
  logic                         w_elem_fire;
  logic                         w_last_lane;
  logic                         w_last_row;
  logic [WIDTH-1:0][DATA_W-1:0] w_commit_vec;

  // Readies depend on state only; the done cycle is blocked so a new command
  // lands no earlier than the cycle after done.
  assign cmd_ready   = (r_state == S_IDLE) && !r_done && !reset;
  assign elem_ready  = (r_state == S_FILL) && !reset;

  assign w_cmd_fire  = cmd_valid && cmd_ready;
  assign w_elem_fire = elem_valid && elem_ready;
  assign w_last_lane = (r_lane == LW'(WIDTH - 1));
  assign w_last_row  = (r_remaining == (AW + 1)'(1));

  // Buffer with the final lane merged in, so the vector commits on the same
  // edge that accepts its last element.
  always_comb begin
    w_commit_vec            = r_buf;
    w_commit_vec[WIDTH - 1] = elem_data;
  end

  // Control FSM and registered cache write port.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_lane        <= '0;
      r_row         <= '0;
      r_remaining   <= '0;
      r_scalar      <= 1'b0;
      r_buf         <= '0;
      r_write_op    <= VEC_DATA_WRITE_DISABLE;
      r_write_addr  <= '0;
      r_write_param <= '0;
      r_vec_data    <= '0;
      r_done        <= 1'b0;
    end else begin
      r_write_op <= VEC_DATA_WRITE_DISABLE;
      r_done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_cmd_fire) begin
            r_row       <= cmd_addr;
            r_remaining <= cmd_count;
            r_scalar    <= cmd_scalar;
            r_lane      <= '0;
            if (cmd_count == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state <= S_FILL;
            end
          end
        end
        S_FILL: begin
          if (w_elem_fire) begin
            r_lane <= r_lane + LW'(1);
            if (r_scalar) begin
              r_write_op    <= VEC_DATA_WRITE_SCALAR;
              r_write_addr  <= r_row;
              r_write_param <= r_lane;
              r_vec_data[0] <= elem_data;
              if (w_last_lane) begin
                r_row       <= r_row + AW'(1);
                r_remaining <= r_remaining - (AW + 1)'(1);
                if (w_last_row) begin
                  r_done  <= 1'b1;
                  r_state <= S_IDLE;
                end
              end
            end else begin
              r_buf[r_lane] <= elem_data;
              if (w_last_lane) begin
                r_write_op   <= VEC_DATA_WRITE_VEC;
                r_write_addr <= r_row;
                r_vec_data   <= w_commit_vec;
                r_done       <= w_last_row;
                r_state      <= S_COMMIT;
              end
            end
          end
        end
        S_COMMIT: begin
          // Write is on the port this cycle; advance bookkeeping for the next row.
          r_row       <= r_row + AW'(1);
          r_remaining <= r_remaining - (AW + 1)'(1);
          r_state     <= w_last_row ? S_IDLE : S_FILL;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign write_op    = r_write_op;
  assign write_addr  = r_write_addr;
  assign write_param = r_write_param;
  assign vec_data    = r_vec_data;
  assign done        = r_done;

endmodule

// File: tb/tb_vec_cache_writer.sv
// Self-checking bench for vec_cache_writer: directed table, multi-cycle
// corner sequences, and randomized commands against a transaction-level model.
`timescale 1ns/1ps
module tb_vec_cache_writer;
  import vec_cache_writer_pkg::*;

  localparam int unsigned WIDTH  = 4;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned LW     = $clog2(WIDTH);
  localparam int unsigned VW     = WIDTH * DATA_W;

  logic                         clock = 1'b0;
  logic                         reset;
  logic                         cmd_valid;
  logic                         cmd_ready;
  logic [AW-1:0]                cmd_addr;
  logic [AW:0]                  cmd_count;
  logic                         cmd_scalar;
  logic                         elem_valid;
  logic                         elem_ready;
  logic [DATA_W-1:0]            elem_data;
  VecDataWriteOp_t              write_op;
  logic [AW-1:0]                write_addr;
  logic [LW-1:0]                write_param;
  logic [WIDTH-1:0][DATA_W-1:0] vec_data;
  logic                         done;

  vec_cache_writer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_count(cmd_count), .cmd_scalar(cmd_scalar),
    .elem_valid(elem_valid), .elem_ready(elem_ready), .elem_data(elem_data),
    .write_op(write_op), .write_addr(write_addr), .write_param(write_param),
    .vec_data(vec_data), .done(done)
  );

  always #5 clock = ~clock;

  typedef struct {
    VecDataWriteOp_t op;
    logic [AW-1:0]   addr;
    logic [LW-1:0]   param;
    logic [VW-1:0]   vec;
    logic            done;
    int              cyc;
  } ev_t;

  typedef struct {
    logic [AW-1:0]     addr;
    logic [AW:0]       count;
    logic              scalar;
    int                n_el;
    logic [DATA_W-1:0] el[8];
    int                stall_at;
    int                n_ev;
    ev_t               ev[4];
  } vec_t;

  ev_t  obs_q[$];
  ev_t  exp_q[$];
  int   hs_q[$];
  int   cyc = 0;
  int   done_cnt = 0;
  int   n_chk = 0;
  int   n_err = 0;

  // Transaction-level model of what the port shows (including held fields).
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_param;
  logic [VW-1:0] m_vec;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
    end
  endtask

  // Record every cycle that carries a write or a done pulse.
  always @(negedge clock) begin
    if (!reset && (write_op != VEC_DATA_WRITE_DISABLE || done)) begin
      obs_q.push_back('{op: write_op, addr: write_addr, param: write_param,
                        vec: VW'(vec_data), done: done, cyc: cyc});
      if (done) done_cnt++;
      if (write_op == VEC_DATA_WRITE_VEC) chk("elem_ready_in_commit", VW'(elem_ready), VW'(0));
    end
    if (!reset && cmd_valid && cmd_ready) hs_q.push_back(cyc);
  end

  function automatic ev_t mk(input VecDataWriteOp_t op, input logic [AW-1:0] a,
                             input logic [LW-1:0] p, input logic [VW-1:0] v, input logic d);
    mk = '{op: op, addr: a, param: p, vec: v, done: d, cyc: 0};
  endfunction

  task automatic model_reset();
    m_addr = '0; m_param = '0; m_vec = '0;
  endtask

  task automatic model_cmd(input logic [AW-1:0] a, input logic [AW:0] c, input logic s,
                           input logic [DATA_W-1:0] el[$]);
    for (int r = 0; r < int'(c); r++) begin
      logic [AW-1:0] row;
      row = AW'((int'(a) + r) % DEPTH);
      if (!s) begin
        for (int l = 0; l < WIDTH; l++) m_vec[l*DATA_W +: DATA_W] = el[r*WIDTH + l];
        m_addr = row;
        exp_q.push_back(mk(VEC_DATA_WRITE_VEC, m_addr, m_param, m_vec, r == int'(c) - 1));
      end else begin
        for (int l = 0; l < WIDTH; l++) begin
          m_addr = row;
          m_param = LW'(l);
          m_vec[DATA_W-1:0] = el[r*WIDTH + l];
          exp_q.push_back(mk(VEC_DATA_WRITE_SCALAR, m_addr, m_param, m_vec,
                             (r == int'(c) - 1) && (l == WIDTH - 1)));
        end
      end
    end
    if (c == '0) exp_q.push_back(mk(VEC_DATA_WRITE_DISABLE, m_addr, m_param, m_vec, 1'b1));
  endtask

  task automatic cmp_events(input string tag);
    chk({tag, "_nevents"}, VW'(obs_q.size()), VW'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      chk($sformatf("%s_op%0d", tag, i),    VW'(obs_q[i].op),    VW'(exp_q[i].op));
      chk($sformatf("%s_addr%0d", tag, i),  VW'(obs_q[i].addr),  VW'(exp_q[i].addr));
      chk($sformatf("%s_param%0d", tag, i), VW'(obs_q[i].param), VW'(exp_q[i].param));
      chk($sformatf("%s_vec%0d", tag, i),   obs_q[i].vec,        exp_q[i].vec);
      chk($sformatf("%s_done%0d", tag, i),  VW'(obs_q[i].done),  VW'(exp_q[i].done));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  // All driver tasks start and end at posedge+1.
  task automatic send_cmd(input logic [AW-1:0] a, input logic [AW:0] c, input logic s,
                          output int hs);
    int n;
    n = 0;
    cmd_addr = a; cmd_count = c; cmd_scalar = s; cmd_valid = 1'b1;
    @(negedge clock);
    while (!cmd_ready && n < 50) begin n++; @(negedge clock); end
    chk("cmd_accept_bound", VW'(n < 50), VW'(1));
    hs = cyc;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic feed(input logic [DATA_W-1:0] el[$], input int stall_at, input int stall_len,
                      input bit rnd, output int waits, output int last);
    waits = 0;
    last = 0;
    for (int i = 0; i < el.size(); i++) begin
      int k;
      int n;
      k = (i == stall_at) ? stall_len : (rnd ? int'($urandom_range(0, 2)) : 0);
      elem_valid = 1'b0;
      repeat (k) begin @(posedge clock); #1; end
      elem_valid = 1'b1;
      elem_data = el[i];
      n = 0;
      @(negedge clock);
      while (!elem_ready && n < 50) begin n++; waits++; @(negedge clock); end
      chk("elem_accept_bound", VW'(n < 50), VW'(1));
      last = cyc;
      @(posedge clock); #1;
    end
    elem_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int d0);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 50) begin @(negedge clock); n++; end
    chk({tag, "_done_seen"}, VW'(done_cnt != d0), VW'(1));
    repeat (2) @(negedge clock);
    @(posedge clock); #1;
  endtask

  task automatic run_cmd(input string tag, input logic [AW-1:0] a, input logic [AW:0] c,
                         input logic s, input logic [DATA_W-1:0] el[$],
                         input int stall_at, input int stall_len, input bit rnd);
    int d0, hs, waits, last;
    d0 = done_cnt;
    send_cmd(a, c, s, hs);
    if (c != '0) begin
      feed(el, stall_at, stall_len, rnd, waits, last);
      if (s) chk({tag, "_scalar_no_backpressure"}, VW'(waits), VW'(0));
    end else begin
      last = hs;
    end
    wait_done(tag, d0);
    if (obs_q.size() > 0)
      chk({tag, "_done_latency"}, VW'(obs_q[obs_q.size()-1].cyc), VW'(last + 1));
  endtask

  vec_t tbl[5];
  logic [DATA_W-1:0] el[$];
  logic [DATA_W-1:0] el_b[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int hs, waits, last, d0;

    // Directed table; entries run in order, so held fields carry over.
    tbl[0] = '{addr: 2'd0, count: 3'd1, scalar: 1'b0, n_el: 4, stall_at: -1, n_ev: 1,
               el: '{32'h40800000, 32'h40C00000, 32'h3F800000, 32'h40C00000, 0, 0, 0, 0},
               ev: '{mk(VEC_DATA_WRITE_VEC, 2'd0, 2'd0,
                        {32'h40C00000, 32'h3F800000, 32'h40C00000, 32'h40800000}, 1'b1),
                     mk(VEC_DATA_WRITE_DISABLE, 0, 0, 0, 0), mk(VEC_DATA_WRITE_DISABLE, 0, 0, 0, 0),
                     mk(VEC_DATA_WRITE_DISABLE, 0, 0, 0, 0)}};
    tbl[1] = '{addr: 2'd3, count: 3'd2, scalar: 1'b0, n_el: 8, stall_at: -1, n_ev: 2,
               el: '{32'h41100000, 32'h40E00000, 32'h40A00000, 32'h40400000,
                     32'h40A00000, 32'h40400000, 32'h00000000, 32'h40400000},
               ev: '{mk(VEC_DATA_WRITE_VEC, 2'd3, 2'd0,
                        {32'h40400000, 32'h40A00000, 32'h40E00000, 32'h41100000}, 1'b0),
                     mk(VEC_DATA_WRITE_VEC, 2'd0, 2'd0,
                        {32'h40400000, 32'h00000000, 32'h40400000, 32'h40A00000}, 1'b1),
                     mk(VEC_DATA_WRITE_DISABLE, 0, 0, 0, 0), mk(VEC_DATA_WRITE_DISABLE, 0, 0, 0, 0)}};
    tbl[2] = '{addr: 2'd1, count: 3'd1, scalar: 1'b1, n_el: 4, stall_at: -1, n_ev: 4,
               el: '{32'h40000000, 32'h40E00000, 32'h40000000, 32'h40400000, 0, 0, 0, 0},
               ev: '{mk(VEC_DATA_WRITE_SCALAR, 2'd1, 2'd0,
                        {32'h40400000, 32'h00000000, 32'h40400000, 32'h40000000}, 1'b0),
                     mk(VEC_DATA_WRITE_SCALAR, 2'd1, 2'd1,
                        {32'h40400000, 32'h00000000, 32'h40400000, 32'h40E00000}, 1'b0),
                     mk(VEC_DATA_WRITE_SCALAR, 2'd1, 2'd2,
                        {32'h40400000, 32'h00000000, 32'h40400000, 32'h40000000}, 1'b0),
                     mk(VEC_DATA_WRITE_SCALAR, 2'd1, 2'd3,
                        {32'h40400000, 32'h00000000, 32'h40400000, 32'h40400000}, 1'b1)}};
    tbl[3] = '{addr: 2'd2, count: 3'd1, scalar: 1'b0, n_el: 4, stall_at: 2, n_ev: 1,
               el: '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 0, 0, 0, 0},
               ev: '{mk(VEC_DATA_WRITE_VEC, 2'd2, 2'd3,
                        {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000}, 1'b1),
                     mk(VEC_DATA_WRITE_DISABLE, 0, 0, 0, 0), mk(VEC_DATA_WRITE_DISABLE, 0, 0, 0, 0),
                     mk(VEC_DATA_WRITE_DISABLE, 0, 0, 0, 0)}};
    tbl[4] = '{addr: 2'd1, count: 3'd0, scalar: 1'b0, n_el: 0, stall_at: -1, n_ev: 1,
               el: '{0, 0, 0, 0, 0, 0, 0, 0},
               ev: '{mk(VEC_DATA_WRITE_DISABLE, 2'd2, 2'd3,
                        {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000}, 1'b1),
                     mk(VEC_DATA_WRITE_DISABLE, 0, 0, 0, 0), mk(VEC_DATA_WRITE_DISABLE, 0, 0, 0, 0),
                     mk(VEC_DATA_WRITE_DISABLE, 0, 0, 0, 0)}};

    reset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_count = '0; cmd_scalar = 1'b0;
    elem_valid = 1'b0; elem_data = '0;
    repeat (3) @(negedge clock);
    chk("rst_cmd_ready",  VW'(cmd_ready),   VW'(0));
    chk("rst_elem_ready", VW'(elem_ready),  VW'(0));
    chk("rst_write_op",   VW'(write_op),    VW'(VEC_DATA_WRITE_DISABLE));
    chk("rst_done",       VW'(done),        VW'(0));
    chk("rst_addr",       VW'(write_addr),  VW'(0));
    chk("rst_param",      VW'(write_param), VW'(0));
    chk("rst_vec",        VW'(vec_data),    VW'(0));
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    chk("idle_cmd_ready", VW'(cmd_ready), VW'(1));
    @(posedge clock); #1;

    for (int t = 0; t < 5; t++) begin
      el.delete();
      for (int i = 0; i < tbl[t].n_el; i++) el.push_back(tbl[t].el[i]);
      run_cmd($sformatf("T%0d", t), tbl[t].addr, tbl[t].count, tbl[t].scalar, el,
              tbl[t].stall_at, 5, 1'b0);
      for (int i = 0; i < tbl[t].n_ev; i++) exp_q.push_back(tbl[t].ev[i]);
      cmp_events($sformatf("T%0d", t));
    end

    // Reset after 2 of 4 elements.
    el.delete(); el.push_back(32'h11111111); el.push_back(32'h22222222);
    send_cmd(2'd0, 3'd1, 1'b0, hs);
    feed(el, -1, 0, 1'b0, waits, last);
    reset = 1'b1;
    #1;
    chk("rstfill_op",         VW'(write_op),   VW'(VEC_DATA_WRITE_DISABLE));
    chk("rstfill_done",       VW'(done),       VW'(0));
    chk("rstfill_elem_ready", VW'(elem_ready), VW'(0));
    chk("rstfill_vec",        VW'(vec_data),   VW'(0));
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;

    // Reset during the commit cycle of a final row.
    el.delete();
    for (int i = 0; i < WIDTH; i++) el.push_back(32'hA0000000 + i);
    send_cmd(2'd2, 3'd1, 1'b0, hs);
    feed(el, -1, 0, 1'b0, waits, last);
    chk("commit_pre_op",   VW'(write_op), VW'(VEC_DATA_WRITE_VEC));
    chk("commit_pre_done", VW'(done),     VW'(1));
    reset = 1'b1;
    #1;
    chk("rstcommit_op",   VW'(write_op), VW'(VEC_DATA_WRITE_DISABLE));
    chk("rstcommit_done", VW'(done),     VW'(0));
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    chk("rst_no_events", VW'(obs_q.size()), VW'(0));
    obs_q.delete();
    model_reset();

    el.delete();
    for (int i = 0; i < WIDTH; i++) el.push_back($urandom());
    model_cmd(2'd1, 3'd1, 1'b0, el);
    run_cmd("rst_fresh", 2'd1, 3'd1, 1'b0, el, -1, 0, 1'b0);
    cmp_events("rst_fresh");

    // cmd_valid held through FILL and across done.
    hs_q.delete();
    el.delete(); el_b.delete();
    for (int i = 0; i < WIDTH; i++) begin el.push_back($urandom()); el_b.push_back($urandom()); end
    model_cmd(2'd1, 3'd1, 1'b0, el);
    model_cmd(2'd3, 3'd1, 1'b0, el_b);
    d0 = done_cnt;
    cmd_addr = 2'd1; cmd_count = 3'd1; cmd_scalar = 1'b0; cmd_valid = 1'b1;
    @(negedge clock);
    @(posedge clock); #1;
    cmd_addr = 2'd3;
    feed(el, -1, 0, 1'b0, waits, last);
    repeat (2) begin @(posedge clock); #1; end
    cmd_valid = 1'b0;
    feed(el_b, -1, 0, 1'b0, waits, last);
    wait_done("b2b", d0 + 1);
    chk("b2b_handshakes", VW'(hs_q.size()), VW'(2));
    if (hs_q.size() >= 2 && obs_q.size() >= 2) begin
      chk("b2b_second_accept", VW'(hs_q[1]), VW'(obs_q[0].cyc + 1));
      chk("b2b_latency",       VW'(obs_q[1].cyc), VW'(last + 1));
    end
    cmp_events("b2b");

    // Randomized commands with random stalls.
    for (int k = 0; k < 16; k++) begin
      logic [AW-1:0] a;
      logic [AW:0]   c;
      logic          s;
      a = AW'($urandom_range(0, DEPTH - 1));
      c = (AW + 1)'($urandom_range(0, DEPTH));
      s = 1'($urandom_range(0, 1));
      el.delete();
      for (int i = 0; i < int'(c) * WIDTH; i++) el.push_back($urandom());
      model_cmd(a, c, s, el);
      run_cmd($sformatf("R%0d", k), a, c, s, el, -1, 0, 1'b1);
      cmp_events($sformatf("R%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
